// File: rtl/reg_hazard_scoreboard_pkg.sv
// Shared types and constants for the register hazard scoreboard.
// A scoreboard entry holds one in-flight destination register.
package reg_hazard_scoreboard_pkg;

  localparam int unsigned REG_W         = 3;
  localparam int unsigned NUM_REGS      = 8;
  localparam int unsigned DEF_DEPTH     = 3;
  localparam int unsigned DEF_RF_BYPASS = 1;
  localparam int unsigned DEF_CNT_W     = 16;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] wreg;
    logic             ld;
  } entry_t;

endpackage

// File: rtl/reg_hazard_cmp.sv
// Compares one in-flight destination register against the ID-stage sources.
// Produces a combinational match bit.
module reg_hazard_cmp
  import reg_hazard_scoreboard_pkg::*;
(
  input  logic             ent_v,
  input  logic [REG_W-1:0] ent_reg,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic             rs_valid,
  input  logic             rt_valid,
  output logic             match_c
);

  assign match_c = ent_v && ((rs_valid && (ent_reg == rs)) ||
                             (rt_valid && (ent_reg == rt)));

endmodule

// File: rtl/reg_hazard_scoreboard.sv
// Shift-register scoreboard of in-flight writes; stalls ID on a RAW hazard.
// Optional macro REG_HAZARD_FWD_EN: with EX/MEM forwarding only load-use stalls.
module reg_hazard_scoreboard
  import reg_hazard_scoreboard_pkg::*;
#(
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned RF_BYPASS = DEF_RF_BYPASS,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [REG_W-1:0]    id_Rs,
  input  logic [REG_W-1:0]    id_Rt,
  input  logic                id_RsValid,
  input  logic                id_RtValid,
  input  logic                id_writeRegValid,
  input  logic [REG_W-1:0]    id_writeReg,
  input  logic                id_isLoad,
  input  logic                flush,
  output logic                stall,
  output logic [NUM_REGS-1:0] pending,
  output logic [CNT_W-1:0]    stall_count
);

`ifdef REG_HAZARD_FWD_EN
  localparam int unsigned WIN = 1;
`else
  localparam int unsigned WIN = DEPTH - RF_BYPASS;
`endif

  entry_t         sb [DEPTH];
  entry_t         load_c;
  logic [WIN-1:0] hit_c;
  logic           hazard_c;
  logic           unused_ld;

  // The oldest entry's load flag has no consumer.
  assign unused_ld = sb[DEPTH-1].ld;

  for (genvar i = 0; i < WIN; i++) begin : g_cmp
    reg_hazard_cmp u_cmp (
      .ent_v    (sb[i].v),
      .ent_reg  (sb[i].wreg),
      .rs       (id_Rs),
      .rt       (id_Rt),
      .rs_valid (id_RsValid),
      .rt_valid (id_RtValid),
      .match_c  (hit_c[i])
    );
  end

`ifdef REG_HAZARD_FWD_EN
  // Forwarding covers everything except a load still in EX.
  assign hazard_c = hit_c[0] && sb[0].ld;
`else
  assign hazard_c = |hit_c;
`endif

  // Flush outranks stall: the killed ID instruction never holds the pipe.
  assign stall = id_valid && !flush && hazard_c;

  always_comb begin
    load_c = '0;
    if (id_valid && id_writeRegValid && !stall && !flush) begin
      load_c.v    = 1'b1;
      load_c.wreg = id_writeReg;
      load_c.ld   = id_isLoad;
    end
  end

  always_comb begin
    pending = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (sb[i].v) pending[sb[i].wreg] = 1'b1;
    end
  end

  // Advance one pipeline slot per cycle; flush kills the instruction leaving EX.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) sb[i] <= '0;
      stall_count <= '0;
    end else begin
      sb[0] <= load_c;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        sb[i] <= (i == 1 && flush) ? '0 : sb[i-1];
      end
      if (stall && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_reg_hazard_scoreboard.sv
// Directed bench for reg_hazard_scoreboard (DEPTH=3, RF_BYPASS=1, narrow counter).
// Expectations switch on REG_HAZARD_FWD_EN to match the build under test.
module tb_reg_hazard_scoreboard;

  localparam int unsigned CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic             id_valid;
  logic [2:0]       id_Rs;
  logic [2:0]       id_Rt;
  logic             id_RsValid;
  logic             id_RtValid;
  logic             id_writeRegValid;
  logic [2:0]       id_writeReg;
  logic             id_isLoad;
  logic             flush;
  logic             stall;
  logic [7:0]       pending;
  logic [CNT_W-1:0] stall_count;

  int n_cmp;
  int n_bad;

  reg_hazard_scoreboard #(.DEPTH(3), .RF_BYPASS(1), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .id_valid         (id_valid),
    .id_Rs            (id_Rs),
    .id_Rt            (id_Rt),
    .id_RsValid       (id_RsValid),
    .id_RtValid       (id_RtValid),
    .id_writeRegValid (id_writeRegValid),
    .id_writeReg      (id_writeReg),
    .id_isLoad        (id_isLoad),
    .flush            (flush),
    .stall            (stall),
    .pending          (pending),
    .stall_count      (stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] rs, input logic rsv,
                       input logic [2:0] rt, input logic rtv, input logic wv,
                       input logic [2:0] wr, input logic ld, input logic fl);
    id_valid         = v;
    id_Rs            = rs;
    id_RsValid       = rsv;
    id_Rt            = rt;
    id_RtValid       = rtv;
    id_writeRegValid = wv;
    id_writeReg      = wr;
    id_isLoad        = ld;
    flush            = fl;
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    clk   = 1'b0;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;

    // Reset with a reader presented
    drive(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    tick();
    check("rst_stall",   32'(stall),       32'd0);
    check("rst_pending", 32'(pending),     32'h00);
    check("rst_count",   32'(stall_count), 32'd0);
    rst_n = 1'b1;

`ifdef REG_HAZARD_FWD_EN
    // Load-use: LD R6 then a reader of R6
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd6, 1'b1, 1'b0);
    check("ldu_writer", 32'(stall), 32'd0);
    tick();
    drive(1'b1, 3'd6, 1'b1, 3'd0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
    check("ldu_stall",   32'(stall),   32'd1);
    check("ldu_pending", 32'(pending), 32'h40);
    tick();
    check("ldu_release", 32'(stall), 32'd0);
    tick();
    idle(3);
    // ALU writer R6 is forwarded
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'd6, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    check("alu_fwd_c1", 32'(stall),   32'd0);
    check("alu_pending", 32'(pending), 32'h40);
    tick();
    check("alu_fwd_c2", 32'(stall), 32'd0);
    idle(3);
    check("fwd_count", 32'(stall_count), 32'd1);
`else
    // RAW: ADD R3 then a reader of R3 stalls two cycles
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
    check("raw_writer", 32'(stall), 32'd0);
    tick();
    drive(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
    check("raw_c1",    32'(stall),   32'd1);
    check("raw_pend1", 32'(pending), 32'h08);
    tick();
    check("raw_c2",    32'(stall),   32'd1);
    check("raw_pend2", 32'(pending), 32'h08);
    tick();
    check("raw_c3",    32'(stall),   32'd0);
    check("raw_pend3", 32'(pending), 32'h08);
    tick();
    check("raw_count", 32'(stall_count), 32'd2);
    idle(3);
`endif

    // No hazard: writer R2, reader R4/R5
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'd4, 1'b1, 3'd5, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    check("nohz_stall", 32'(stall),   32'd0);
    check("nohz_p1",    32'(pending), 32'h04);
    tick();
    idle(0);
    check("nohz_p2", 32'(pending), 32'h04);
    tick();
    check("nohz_p3", 32'(pending), 32'h04);
    tick();
    check("nohz_p4", 32'(pending), 32'h00);

    // Rt read only counts when RtValid is set
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'd1, 1'b0, 3'd5, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    check("rtv_gate", 32'(stall), 32'd0);
    tick();
    drive(1'b1, 3'd1, 1'b0, 3'd5, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
`ifdef REG_HAZARD_FWD_EN
    check("rtv_read", 32'(stall), 32'd0);
`else
    check("rtv_read", 32'(stall), 32'd1);
`endif
    tick();
    idle(2);
`ifdef REG_HAZARD_FWD_EN
    check("cnt_mid", 32'(stall_count), 32'd1);
`else
    check("cnt_mid", 32'(stall_count), 32'd3);
`endif

    // Flush beats stall and kills the EX entry
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 1'b1, 3'd7, 1'b0, 1'b1);
    check("flush_stall", 32'(stall),   32'd0);
    check("flush_pend",  32'(pending), 32'h02);
    tick();
    idle(0);
    check("flush_kill", 32'(pending), 32'h00);

    // Counter saturation, then reset in the middle of a stall
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0);
    tick();
    drive(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    check("mid_s1", 32'(stall), 32'd1);
    tick();
`ifdef REG_HAZARD_FWD_EN
    check("cnt_sat", 32'(stall_count), 32'd2);
    check("mid_s2",  32'(stall),       32'd0);
`else
    check("cnt_sat", 32'(stall_count), 32'd3);
    check("mid_s2",  32'(stall),       32'd1);
`endif
    rst_n = 1'b0;
    tick();
    check("mid_rst_stall", 32'(stall),       32'd0);
    check("mid_rst_pend",  32'(pending),     32'h00);
    check("mid_rst_count", 32'(stall_count), 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_stall", 32'(stall), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
